pipelined_adder_subtractor: RTL and testbench
=============================================

PIPELINED_ADDER_SUBTRACTOR -- requirements
Module: pipelined_adder_subtractor

Interface
REQ-001 SHALL have parameter N, default 8: operand and result width in bits (N >= 2).
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; each stage processes N/STAGES bits (N % STAGES == 0; 1 <= STAGES <= N).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port A, input, N bits: first operand.
REQ-006 SHALL have port B, input, N bits: second operand.
REQ-007 SHALL have port sub, input, 1 bit: 0 computes A+B; 1 computes A-B (two's complement: A + ~B + 1).
REQ-008 SHALL have port in_valid, input, 1 bit: A, B and sub are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the operands this cycle.
REQ-010 SHALL have port S, output, N bits: result, modulo 2^N.
REQ-011 SHALL have port out_valid, output, 1 bit: S and the flags are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-013 SHALL accept a transfer when in_valid && in_ready, and SHALL retire one when out_valid && out_ready.
REQ-014 SHALL split the add into STAGES ripple-carry slices; stage k adds bits [(k+1)*N/STAGES-1 : k*N/STAGES] using the registered carry from stage k-1.
REQ-015 SHALL register the stage-0 carry-in as sub; the upper operand bits, sub and the partial sum SHALL travel with the carry through the stages.
REQ-016 SHALL hold a valid bit per stage; with no stall, an operation accepted in cycle t SHALL raise out_valid in cycle t+STAGES.
REQ-017 SHALL stall every stage together while out_valid && !out_ready; during a stall no stage register or valid bit changes.
REQ-018 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-019 SHALL sustain one operation per cycle when in_valid and out_ready are both held high.
REQ-020 SHALL deliver results in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-021 SHALL hold S (and the flags, if built in) stable while out_valid && !out_ready.
REQ-022 SHALL let bubbles (stages with valid=0) advance; a bubble SHALL never raise out_valid.
REQ-023 SHALL not drive in_ready from the inputs in_valid, A, B or sub.
REQ-024 SHALL ignore in_valid in any cycle where rst is high.

Reset
REQ-025 SHALL clear all stage valid bits on a clock edge with rst=1, so out_valid=0 the next cycle.
REQ-026 SHALL drive S and the flags to all-zero after reset.
REQ-027 SHALL discard every in-flight operation when rst is asserted mid-operation; none SHALL emerge after rst is released.
REQ-028 SHALL have in_ready=1 in the first cycle after reset.

Configuration
REQ-029 SHALL add the outputs cout, overflow and zero (1 bit each) when the macro ADDSUB_FLAGS_EN is defined.
REQ-030 cout SHALL be the carry out of bit N-1; for sub=1 it SHALL mean no borrow (cout=1 iff A >= B unsigned).
REQ-031 overflow SHALL be the carry into bit N-1 XOR the carry out of bit N-1 (signed overflow); zero SHALL be 1 iff S==0.
REQ-032 The flags SHALL be aligned with S and qualified by out_valid.
REQ-033 When ADDSUB_FLAGS_EN is undefined, the flag ports and their logic SHALL be absent; S and the handshake behaviour SHALL be unchanged.

Verification (N=8, STAGES=2, ADDSUB_FLAGS_EN defined unless stated)
REQ-034 SHALL test: 100+27, out_ready=1 -> two cycles later S=127, cout=0, overflow=0, zero=0.
REQ-035 SHALL test: 127+1 -> S=0x80, overflow=1; then 0x80-1 (sub=1) -> S=0x7F, overflow=1, cout=1.
REQ-036 SHALL test: 5-7 -> S=0xFE, cout=0, overflow=0; then 9-9 -> S=0x00, zero=1, cout=1.
REQ-037 SHALL test: back-to-back inputs 1+1, 2+2, 3+3 with out_ready low for 4 cycles -> in_ready drops; S holds 2, then 2, 4, 6 in order after out_ready rises.
REQ-038 SHALL test: rst pulsed one cycle while two operations are in flight -> out_valid=0 next cycle; no stale result appears over the following 4 cycles.
REQ-039 SHALL test: rebuild without ADDSUB_FLAGS_EN and with STAGES=1, N=4, run 7+9 -> S=0 after 1 cycle; the flag ports do not exist.

Source files
------------

// File: rtl/pipelined_adder_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_adder_subtractor
//
// Purpose:
//   N-bit adder/subtractor split into STAGES ripple-carry slices of N/STAGES
//   bits. Each slice is computed combinationally from the previous stage
//   register and then registered. The carry, the partial sum, the remaining
//   operand bits and the sub flag move forward together. A valid/ready
//   handshake on both sides stalls the whole pipeline while the output is
//   held.
//
// Parameters:
//   N       operand and result width (N >= 2)
//   STAGES  pipeline depth (N % STAGES == 0, 1 <= STAGES <= N)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   A, B       operands
//   sub        0: A+B, 1: A-B (A + ~B + 1)
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle
//   S          result modulo 2^N
//   out_valid  S (and flags) valid
//   out_ready  consumer takes the result this cycle
//   cout, overflow, zero   (only when ADDSUB_FLAGS_EN is defined)
//                          carry out of bit N-1, signed overflow, S==0
//
// Build option:
//   ADDSUB_FLAGS_EN  adds the cout/overflow/zero outputs and their logic.
// -----------------------------------------------------------------------------
module pipelined_adder_subtractor #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] S,
  output logic         out_valid,
`ifdef ADDSUB_FLAGS_EN
  output logic         cout,
  output logic         overflow,
  output logic         zero,
`endif
  input  logic         out_ready
);

  localparam int W = N / STAGES;

  // One pipeline stage. b holds the already-conditioned operand (~B for sub),
  // carry is the carry out of the slice this stage computed, c_msb is the
  // carry into bit N-1 (only meaningful once the top slice has been added).
  typedef struct packed {
    logic         valid;
    logic         sub;
    logic         carry;
    logic         c_msb;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
  } stage_t;

  stage_t pipe_q [STAGES];
  stage_t pipe_d [STAGES];
  logic   stall;

  // The stall depends only on registered state and out_ready, never on the
  // input side, so in_ready carries no path from in_valid/A/B/sub.
  assign stall    = pipe_q[STAGES-1].valid && !out_ready;
  assign in_ready = !stall;

  // Next value of every stage: stage k adds its slice onto what stage k-1
  // holds (stage 0 takes the raw inputs with carry-in = sub).
  always_comb begin
    stage_t src;
    logic   c;
    int     prev;
    int     bit_i;
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: every variable gets a value on every pass before it is read,
      // so no latch is inferred for src, c or pipe_d.
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src.valid = in_valid;
        src.sub   = sub;
        src.carry = sub;
        src.c_msb = 1'b0;
        src.a     = A;
        src.b     = B ^ {N{sub}};
        src.s     = '0;
      end else begin
        src = pipe_q[prev];
      end
      pipe_d[k] = src;
      c = src.carry;
      for (int i = 0; i < W; i++) begin
        bit_i = k * W + i;
        if (bit_i == N - 1) pipe_d[k].c_msb = c;
        pipe_d[k].s[bit_i] = src.a[bit_i] ^ src.b[bit_i] ^ c;
        c = (src.a[bit_i] & src.b[bit_i]) | (c & (src.a[bit_i] ^ src.b[bit_i]));
      end
      pipe_d[k].carry = c;
    end
  end

  // NOTE: the whole stage contents are reset, not just the valid bits, so
  // that S reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign S         = pipe_q[STAGES-1].s;

`ifdef ADDSUB_FLAGS_EN
  // Flags are forced low whenever no result is presented, so they read zero
  // after reset and never describe a bubble.
  assign cout     = out_valid & pipe_q[STAGES-1].carry;
  assign overflow = out_valid & (pipe_q[STAGES-1].c_msb ^ pipe_q[STAGES-1].carry);
  assign zero     = out_valid & (pipe_q[STAGES-1].s == '0);
`endif

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_subtractor
//
// Directed bench for pipelined_adder_subtractor: an N=8/STAGES=2 instance for
// arithmetic, handshake and reset scenarios, plus an N=4/STAGES=1 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Flag checks are compiled in only when ADDSUB_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, s;
  logic       sub_op, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a4, b4, s4;
  logic       sub4, iv4, ir4, ov4, or4;
`ifdef ADDSUB_FLAGS_EN
  logic       cout, overflow, zero;
  logic       cout4, overflow4, zero4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_adder_subtractor #(.N(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .sub(sub_op),
    .in_valid(in_valid), .in_ready(in_ready), .S(s), .out_valid(out_valid),
`ifdef ADDSUB_FLAGS_EN
    .cout(cout), .overflow(overflow), .zero(zero),
`endif
    .out_ready(out_ready)
  );

  pipelined_adder_subtractor #(.N(4), .STAGES(1)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .sub(sub4),
    .in_valid(iv4), .in_ready(ir4), .S(s4), .out_valid(ov4),
`ifdef ADDSUB_FLAGS_EN
    .cout(cout4), .overflow(overflow4), .zero(zero4),
`endif
    .out_ready(or4)
  );

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub_op = 1'b0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; sub4 = 1'b0;
    @(negedge clk);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL reset_s: got %h want 00", s); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (ov4 !== 1'b0 || s4 !== 4'h0) begin n_bad++; $display("FAIL reset_n4: got v=%b s=%h want v=0 s=0", ov4, s4); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if ({cout, overflow, zero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {cout, overflow, zero}); end
`endif
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  task automatic test_arith();
    vec_t vecs[7];
    vecs[0] = '{8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h7F,  8'h01, 1'b0, 8'h80,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h80,  8'h01, 1'b1, 8'h7F,  1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'd5,   8'd7,  1'b1, 8'hFE,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'd9,   8'd9,  1'b1, 8'h00,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h0F,  8'h01, 1'b0, 8'h10,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = vecs[i].a; b = vecs[i].b; sub_op = vecs[i].sub; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arith%0d_latency: out_valid=%b after 1 cycle, want 0", i, out_valid); end
      next_cycle();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arith%0d_valid: out_valid=%b after 2 cycles, want 1", i, out_valid); end
      n_cmp++; if (s !== vecs[i].s) begin n_bad++; $display("FAIL arith%0d_s: got %h want %h", i, s, vecs[i].s); end
`ifdef ADDSUB_FLAGS_EN
      n_cmp++; if ({cout, overflow, zero} !== {vecs[i].c, vecs[i].v, vecs[i].z})
        begin n_bad++; $display("FAIL arith%0d_flags: got cvz=%b want %b", i, {cout, overflow, zero}, {vecs[i].c, vecs[i].v, vecs[i].z}); end
`endif
    end
    next_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arith_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops[3];
    logic [7:0] exp[3];
    int sent = 0, got = 0;
    logic saw_not_ready = 1'b0;
    ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3;
    exp[0] = 8'd2; exp[1] = 8'd4; exp[2] = 8'd6;
    sub_op = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 3);
      a = ops[(sent < 3) ? sent : 2];
      b = a;
      #1;
      if (!in_ready) saw_not_ready = 1'b1;
      if (out_valid && !out_ready) begin
        n_cmp++; if (s !== exp[got]) begin n_bad++; $display("FAIL b2b_hold cyc%0d: got %h want %h", cyc, s, exp[got]); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (s !== exp[got]) begin n_bad++; $display("FAIL b2b_order%0d: got %h want %h", got, s, exp[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d results want 3 (timeout)", got); end
    n_cmp++; if (saw_not_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_drop: saw_low=%b want 1", saw_not_ready); end
    next_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; sub_op = 1'b0;
    a = 8'd10; b = 8'd20; in_valid = 1'b1;
    next_cycle();
    a = 8'd30; b = 8'd40;
    next_cycle();
    n_cmp++; if (out_valid !== 1'b1 || s !== 8'd30) begin n_bad++; $display("FAIL rstmid_inflight: got v=%b s=%h want v=1 s=1e", out_valid, s); end
    // Reset with in_valid still high: that operand must be ignored too.
    rst = 1'b1; a = 8'd50; b = 8'd50;
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_cleared: out_valid=%b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale%0d: out_valid=%b s=%h want out_valid=0", i, out_valid, s); end
    end
  endtask

  task automatic test_n4_single_stage();
    or4 = 1'b1;
    a4 = 4'd7; b4 = 4'd9; sub4 = 1'b0; iv4 = 1'b1;
    next_cycle();
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b1;
    n_cmp++; if (ov4 !== 1'b1 || s4 !== 4'h0) begin n_bad++; $display("FAIL n4_7p9: got v=%b s=%h want v=1 s=0", ov4, s4); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if ({cout4, overflow4, zero4} !== 3'b101) begin n_bad++; $display("FAIL n4_7p9_flags: got %b want 101", {cout4, overflow4, zero4}); end
`endif
    next_cycle();
    iv4 = 1'b0;
    n_cmp++; if (ov4 !== 1'b1 || s4 !== 4'hE) begin n_bad++; $display("FAIL n4_3m5: got v=%b s=%h want v=1 s=e", ov4, s4); end
    next_cycle();
    n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL n4_drain: out_valid=%b want 0", ov4); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_n4_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
